// File: rtl/bullet_pool_pkg.sv
// Shared screen and bullet geometry constants for the shooter datapath.
// Reused by the ship, enemy and bullet blocks.
package bullet_pool_pkg;

    localparam int SCREEN_W     = 640;
    localparam int COORD_W      = 10;
    localparam int XW           = COORD_W + 1;
    localparam int DEF_B_WIDTH  = 12;
    localparam int DEF_B_HEIGHT = 3;
    localparam int DEF_B_SPEED  = 30;
    localparam int CD_W         = 8;

    function automatic logic [XW-1:0] widen(input logic [COORD_W-1:0] c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: active flag, position, per-frame move/retire
// and the pixel hit-test used by the draw path.
module bullet_slot
    import bullet_pool_pkg::*;
#(
    parameter int B_WIDTH  = DEF_B_WIDTH,
    parameter int B_HEIGHT = DEF_B_HEIGHT,
    parameter int B_SPEED  = DEF_B_SPEED,
    parameter int X_LIMIT  = SCREEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               spawn,
    input  logic               kill,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               active,
    output logic               covers
);

    logic               active_q, active_d;
    logic [COORD_W-1:0] bx_q, bx_d;
    logic [COORD_W-1:0] by_q, by_d;
    logic [XW-1:0]      nx;
    logic [XW-1:0]      px, py, xe, ye;

    // Spawn only targets free slots, so it never races a live kill.
    always_comb begin
        active_d = active_q;
        bx_d     = bx_q;
        by_d     = by_q;
        nx       = widen(bx_q) + XW'(B_SPEED);
        if (spawn) begin
            active_d = 1'b1;
            bx_d     = spawn_x;
            by_d     = spawn_y;
        end else if (kill) begin
            active_d = 1'b0;
        end else if (tick && active_q) begin
            if (nx >= XW'(X_LIMIT)) begin
                active_d = 1'b0;
            end else begin
                bx_d = nx[COORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
        end else begin
            active_q <= active_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
        end
    end

    always_comb begin
        px     = widen(pix_x);
        py     = widen(pix_y);
        xe     = widen(bx_q);
        ye     = widen(by_q);
        covers = active_q
               && (px >= xe) && (px < xe + XW'(B_WIDTH))
               && (py >= ye) && (py < ye + XW'(B_HEIGHT));
    end

    assign active = active_q;

endmodule

// File: rtl/bullet_pool.sv
// Multi-bullet projectile engine: frame tick, slot pool, cooldown,
// hit decode and the per-pixel draw strobe for the VGA mixer.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int N_BULLETS = 4,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int B_HEIGHT  = DEF_B_HEIGHT,
    parameter int B_SPEED   = DEF_B_SPEED,
    parameter int X_LIMIT   = SCREEN_W,
    parameter int OFF_X     = 25,
    parameter int OFF_Y     = 14,
    parameter int COOLDOWN  = 8,
    parameter int IDX_W     = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 v_sync,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic                 shoot,
    input  logic [9:0]           ship_x,
    input  logic [9:0]           ship_y,
    input  logic                 hit_valid,
    input  logic [IDX_W-1:0]     hit_idx,
    output logic [N_BULLETS-1:0] active_mask,
    output logic                 fire_pulse,
    output logic                 bullet_on,
    output logic [IDX_W-1:0]     bullet_idx
);

    logic                 v_sync_q, v_sync_d;
    logic                 armed_q, armed_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 fire_pulse_q, fire_pulse_d;
    logic                 tick, fire;
    logic [N_BULLETS-1:0] active, covers;
    logic [N_BULLETS-1:0] free_oh, spawn_vec, kill_vec;
    logic [COORD_W-1:0]   spawn_x, spawn_y;

    // armed_q forces a fresh low-then-high on v_sync after reset.
    always_comb begin
        v_sync_d = v_sync;
        armed_d  = armed_q | ~v_sync;
        tick     = v_sync & ~v_sync_q & armed_q;
        free_oh  = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
        fire      = tick & shoot & (cd_q == '0) & (|free_oh);
        spawn_vec = fire ? free_oh : '0;
        spawn_x   = ship_x + COORD_W'(OFF_X);
        spawn_y   = ship_y + COORD_W'(OFF_Y);
        cd_d      = cd_q;
        if (fire) begin
            cd_d = CD_W'(COOLDOWN);
        end else if (tick && cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end
        fire_pulse_d = fire;
    end

    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            kill_vec[i] = hit_valid && (hit_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q     <= 1'b0;
            armed_q      <= 1'b0;
            cd_q         <= '0;
            fire_pulse_q <= 1'b0;
        end else begin
            v_sync_q     <= v_sync_d;
            armed_q      <= armed_d;
            cd_q         <= cd_d;
            fire_pulse_q <= fire_pulse_d;
        end
    end

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .B_WIDTH  (B_WIDTH),
            .B_HEIGHT (B_HEIGHT),
            .B_SPEED  (B_SPEED),
            .X_LIMIT  (X_LIMIT)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .spawn   (spawn_vec[g]),
            .kill    (kill_vec[g]),
            .spawn_x (spawn_x),
            .spawn_y (spawn_y),
            .pix_x   (pix_x),
            .pix_y   (pix_y),
            .active  (active[g]),
            .covers  (covers[g])
        );
    end

    always_comb begin
        bullet_on  = |covers;
        bullet_idx = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (covers[i]) begin
                bullet_idx = IDX_W'(i);
            end
        end
    end

    assign active_mask = active;
    assign fire_pulse  = fire_pulse_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with a short cooldown so the
// pool-full, retire, hit and overlap cases fit in a few frames.
module tb_bullet_pool;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_sync;
    logic [9:0] pix_x, pix_y;
    logic       shoot;
    logic [9:0] ship_x, ship_y;
    logic       hit_valid;
    logic [1:0] hit_idx;
    logic [3:0] active_mask;
    logic       fire_pulse;
    logic       bullet_on;
    logic [1:0] bullet_idx;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bullet_pool #(
        .COOLDOWN (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .v_sync      (v_sync),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .shoot       (shoot),
        .ship_x      (ship_x),
        .ship_y      (ship_y),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .active_mask (active_mask),
        .fire_pulse  (fire_pulse),
        .bullet_on   (bullet_on),
        .bullet_idx  (bullet_idx)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic hv, input logic [1:0] hi);
        cyc(1);
        v_sync    = 1'b1;
        hit_valid = hv;
        hit_idx   = hi;
        cyc(1);
        v_sync    = 1'b0;
        hit_valid = 1'b0;
    endtask

    task automatic probe(input string tag, input int px, input int py,
                         input logic on, input logic [1:0] idx);
        @(negedge clk);
        pix_x = 10'(px);
        pix_y = 10'(py);
        #1;
        check({tag, "_on"}, bullet_on, on);
        check({tag, "_idx"}, bullet_idx, idx);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        v_sync    = 1'b0;
        shoot     = 1'b0;
        hit_valid = 1'b0;
        hit_idx   = '0;
        pix_x     = '0;
        pix_y     = '0;
        ship_x    = '0;
        ship_y    = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    logic [3:0] a_mask [20] = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3,
                                4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF,
                                4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                4'hE, 4'hF};
    logic       a_fire [20] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1,
                                0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        do_reset();
        check("rst_mask", active_mask, 0);
        check("rst_fire", fire_pulse, 0);
        check("rst_on", bullet_on, 0);
        check("rst_idx", bullet_idx, 0);

        // Fire cadence, pool full, retire at the edge, refill.
        shoot  = 1'b1;
        ship_x = 10'd100;
        ship_y = 10'd200;
        for (int t = 1; t <= 20; t++) begin
            frame(1'b0, 2'd0);
            check($sformatf("mask_t%0d", t), active_mask, a_mask[t-1]);
            check($sformatf("fire_t%0d", t), fire_pulse, a_fire[t-1]);
            cyc(1);
            check($sformatf("fire_low_t%0d", t), fire_pulse, 0);
            if (t == 1) begin
                probe("t1_org", 125, 214, 1, 0);
                probe("t1_left", 124, 214, 0, 0);
                probe("t1_right", 136, 214, 1, 0);
                probe("t1_past", 137, 214, 0, 0);
                probe("t1_bot", 125, 216, 1, 0);
                probe("t1_below", 125, 217, 0, 0);
                probe("t1_above", 125, 213, 0, 0);
            end
            if (t == 13) probe("t13_s0", 485, 214, 1, 0);
            if (t == 18) begin
                probe("t18_s0", 635, 214, 1, 0);
                probe("t18_edge", 646, 214, 1, 0);
                probe("t18_past", 647, 214, 0, 0);
            end
            if (t == 19) probe("t19_gone", 635, 214, 0, 0);
            if (t == 20) begin
                probe("t20_s0", 125, 214, 1, 0);
                probe("t20_s3", 425, 214, 1, 3);
            end
        end

        // Hit on the tick clk beats both move and refire.
        do_reset();
        shoot  = 1'b1;
        ship_x = 10'd100;
        ship_y = 10'd200;
        for (int t = 1; t <= 6; t++) frame(1'b0, 2'd0);
        check("hit_pre_mask", active_mask, 4'h3);
        frame(1'b1, 2'd1);
        check("hit_tick_mask", active_mask, 4'h5);
        check("hit_tick_fire", fire_pulse, 1);
        frame(1'b0, 2'd0);
        frame(1'b0, 2'd0);
        check("hit_t9_mask", active_mask, 4'h5);
        frame(1'b0, 2'd0);
        check("refire_mask", active_mask, 4'h7);
        check("refire_fire", fire_pulse, 1);
        probe("refire_s1", 125, 214, 1, 1);
        cyc(1);
        hit_valid = 1'b1;
        hit_idx   = 2'd0;
        cyc(1);
        hit_valid = 1'b0;
        check("hit_s0_mask", active_mask, 4'h6);
        probe("hit_s0_gone", 395, 214, 0, 0);
        cyc(1);
        hit_valid = 1'b1;
        hit_idx   = 2'd3;
        cyc(1);
        hit_valid = 1'b0;
        check("hit_idle_mask", active_mask, 4'h6);

        // Overlapping bullets resolve to the lower slot.
        do_reset();
        shoot  = 1'b1;
        ship_x = 10'd185;
        ship_y = 10'd200;
        frame(1'b0, 2'd0);
        frame(1'b0, 2'd0);
        frame(1'b0, 2'd0);
        ship_x = 10'd270;
        frame(1'b0, 2'd0);
        check("ovl_mask", active_mask, 4'h3);
        check("ovl_fire", fire_pulse, 1);
        probe("ovl_both", 300, 214, 1, 0);
        probe("ovl_s1", 296, 214, 1, 1);
        probe("ovl_s0", 306, 214, 1, 0);
        probe("ovl_end", 312, 214, 0, 0);
        probe("ovl_pre", 294, 214, 0, 0);
        probe("ovl_ylow", 300, 217, 0, 0);

        // Retire from x=600: moves to 630, then 660 clears it.
        do_reset();
        shoot  = 1'b1;
        ship_x = 10'd575;
        ship_y = 10'd200;
        frame(1'b0, 2'd0);
        shoot = 1'b0;
        probe("r600", 600, 214, 1, 0);
        frame(1'b0, 2'd0);
        check("r630_mask", active_mask, 4'h1);
        probe("r630", 630, 214, 1, 0);
        probe("r630_edge", 641, 214, 1, 0);
        probe("r630_past", 642, 214, 0, 0);
        frame(1'b0, 2'd0);
        check("r660_mask", active_mask, 4'h0);
        check("r660_fire", fire_pulse, 0);
        probe("r660_gone", 630, 214, 0, 0);

        // Async reset mid-frame, then v_sync held high across release.
        do_reset();
        shoot  = 1'b1;
        ship_x = 10'd100;
        ship_y = 10'd200;
        for (int t = 1; t <= 7; t++) frame(1'b0, 2'd0);
        pix_x = 10'd305;
        pix_y = 10'd214;
        #1;
        check("mid_mask", active_mask, 4'h7);
        check("mid_fire", fire_pulse, 1);
        check("mid_on", bullet_on, 1);
        rst_n  = 1'b0;
        v_sync = 1'b1;
        #1;
        check("arst_mask", active_mask, 0);
        check("arst_fire", fire_pulse, 0);
        check("arst_on", bullet_on, 0);
        check("arst_idx", bullet_idx, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        check("held_mask", active_mask, 0);
        check("held_fire", fire_pulse, 0);
        v_sync = 1'b0;
        cyc(1);
        v_sync = 1'b1;
        cyc(1);
        v_sync = 1'b0;
        check("fresh_mask", active_mask, 4'h1);
        check("fresh_fire", fire_pulse, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
